// File: rtl/intt_pass_scheduler.sv
// rtl/intt_pass_scheduler.sv - splits one inverse NTT into iNTTControl_v2 passes of up to LOGE levels
module intt_pass_scheduler #(
  parameter int LOGN    = 13,
  parameter int LOGE    = 3,
  parameter int FSIZE   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [FSIZE-1:0] cmd_p,
  input  logic [LOGE-1:0]  cmd_diff_logN,
  output logic             start_NTT,
  output logic [FSIZE-1:0] p,
  output logic [LOGE-1:0]  NTT_levels,
  output logic [LOGN-1:0]  NTT_base_level,
  output logic [LOGE-1:0]  diff_logN,
  input  logic             NTT_working,
  output logic [LOGN-1:0]  pass_idx,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  localparam int RW = LOGN + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] LOGE_R   = RW'(LOGE);

  state_t           state_q, state_d;
  // Levels still to run after the pass currently issued; doubles as that pass's base level.
  logic [RW-1:0]    rem_q, rem_d;
  logic [LOGE-1:0]  lvls_q, lvls_d;
  logic [FSIZE-1:0] p_q, p_d;
  logic [LOGE-1:0]  diff_q, diff_d;
  logic [LOGN-1:0]  pass_q, pass_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [31:0]      diff_wide;
  logic [RW-1:0]    l_cmd;
  logic [RW-1:0]    r_src;
  logic [RW-1:0]    n_ext;
  logic [LOGE-1:0]  n_src;

  // Active level count of a new command (saturating at 0) and the size of the next pass.
  always_comb begin
    diff_wide = 32'(cmd_diff_logN);
    l_cmd     = (diff_wide >= 32'(LOGN)) ? '0 : RW'(32'(LOGN) - diff_wide);
    r_src     = (state_q == S_IDLE) ? l_cmd : rem_q;
    n_ext     = (r_src < LOGE_R) ? r_src : LOGE_R;
    n_src     = LOGE'(n_ext);
  end

  // Next-state logic: pass sequencing, per-phase timeout and command latching.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lvls_d  = lvls_q;
    p_d     = p_q;
    diff_d  = diff_q;
    pass_d  = pass_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          p_d    = cmd_p;
          diff_d = cmd_diff_logN;
          pass_d = '0;
          err_d  = 1'b0;
          if (l_cmd == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            lvls_d  = n_src;
            rem_d   = r_src - n_ext;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_START;
        cnt_d   = '0;
      end
      S_WAIT_START: begin
        if (NTT_working) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!NTT_working) begin
          if (rem_q != '0) begin
            state_d = S_ISSUE;
            pass_d  = pass_q + LOGN'(1);
            lvls_d  = n_src;
            rem_d   = r_src - n_ext;
          end else begin
            state_d = S_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any pass in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      lvls_q  <= '0;
      p_q     <= '0;
      diff_q  <= '0;
      pass_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lvls_q  <= lvls_d;
      p_q     <= p_d;
      diff_q  <= diff_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign start_NTT      = (state_q == S_ISSUE);
  assign done           = (state_q == S_DONE);
  assign p              = p_q;
  assign NTT_levels     = lvls_q;
  assign NTT_base_level = rem_q[LOGN-1:0];
  assign diff_logN      = diff_q;
  assign pass_idx       = pass_q;
  assign error          = err_q;

endmodule

// File: tb/tb_intt_pass_scheduler.sv
// tb/tb_intt_pass_scheduler.sv - scoreboard bench for intt_pass_scheduler
module tb_intt_pass_scheduler;
  localparam int LOGN   = 13;
  localparam int LOGE   = 3;
  localparam int LOGE_B = 4;
  localparam int FSIZE  = 32;
  localparam int TO     = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [FSIZE-1:0] cmd_p = '0;
  logic [LOGE-1:0]  cmd_diff_logN = '0;
  logic             start_NTT;
  logic [FSIZE-1:0] p;
  logic [LOGE-1:0]  NTT_levels, diff_logN;
  logic [LOGN-1:0]  NTT_base_level, pass_idx;
  logic             NTT_working = 1'b0;
  logic             done, error;

  logic               cmd_valid_b = 1'b0;
  logic               cmd_ready_b;
  logic [FSIZE-1:0]   cmd_p_b = '0;
  logic [LOGE_B-1:0]  cmd_diff_logN_b = '0;
  logic               start_NTT_b;
  logic [FSIZE-1:0]   p_b;
  logic [LOGE_B-1:0]  NTT_levels_b, diff_logN_b;
  logic [LOGN-1:0]    NTT_base_level_b, pass_idx_b;
  logic               NTT_working_b = 1'b0;
  logic               done_b, error_b;

  intt_pass_scheduler #(.LOGN(LOGN), .LOGE(LOGE), .FSIZE(FSIZE), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_p(cmd_p),
    .cmd_diff_logN(cmd_diff_logN), .start_NTT(start_NTT), .p(p), .NTT_levels(NTT_levels),
    .NTT_base_level(NTT_base_level), .diff_logN(diff_logN), .NTT_working(NTT_working),
    .pass_idx(pass_idx), .done(done), .error(error)
  );

  intt_pass_scheduler #(.LOGN(LOGN), .LOGE(LOGE_B), .FSIZE(FSIZE), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_p(cmd_p_b),
    .cmd_diff_logN(cmd_diff_logN_b), .start_NTT(start_NTT_b), .p(p_b), .NTT_levels(NTT_levels_b),
    .NTT_base_level(NTT_base_level_b), .diff_logN(diff_logN_b), .NTT_working(NTT_working_b),
    .pass_idx(pass_idx_b), .done(done_b), .error(error_b)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // iNTTControl_v2 stand-in: working rises after the start pulse, held for w cycles of sampling.
  int w_a = 10;
  int hold_a = 0;
  bit hang_a = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      NTT_working = 1'b0;
      hold_a = 0;
    end else if (start_NTT) begin
      NTT_working = 1'b1;
      hold_a = w_a + 1;
    end else if (hold_a > 0 && !hang_a) begin
      hold_a--;
      if (hold_a == 0) NTT_working = 1'b0;
    end
  end

  int hold_b = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      NTT_working_b = 1'b0;
      hold_b = 0;
    end else if (start_NTT_b) begin
      NTT_working_b = 1'b1;
      hold_b = 4 + 1;
    end else if (hold_b > 0) begin
      hold_b--;
      if (hold_b == 0) NTT_working_b = 1'b0;
    end
  end

  typedef struct packed {
    logic [LOGN-1:0]  base;
    logic [LOGE-1:0]  lvls;
    logic [LOGN-1:0]  idx;
    logic [FSIZE-1:0] p;
    logic [LOGE-1:0]  diff;
  } start_t;

  typedef struct packed {
    logic        err;
    logic [31:0] lat;
  } done_t;

  typedef struct packed {
    logic [LOGE-1:0]        diff;
    logic [FSIZE-1:0]       p;
    logic [7:0]             w;
    logic [3:0]             k;
    logic [4:0][LOGN-1:0]   base;
    logic [4:0][LOGE-1:0]   lvls;
  } vec_t;

  start_t sq[$];
  done_t  dq[$];
  int acc_cyc = 0;
  int starts_seen = 0;
  int dones_seen = 0;

  // Scoreboard side: every start and done pulse of the main instance is matched to a queued expectation.
  always @(negedge clk) begin
    start_t se;
    done_t de;
    if (start_NTT) begin
      starts_seen++;
      if (sq.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        se = sq.pop_front();
        chk("base_level", NTT_base_level, se.base);
        chk("levels", NTT_levels, se.lvls);
        chk("pass_idx", pass_idx, se.idx);
        chk("p", p, se.p);
        chk("diff_logN", diff_logN, se.diff);
      end
    end
    if (done) begin
      dones_seen++;
      if (dq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        de = dq.pop_front();
        chk("done_error", error, de.err);
        chk("latency", cyc - acc_cyc + 2, de.lat);
      end
    end
  end

  task automatic push_start(input int base, input int lvls, input int idx, input logic [FSIZE-1:0] pv, input int d);
    start_t s;
    s.base = LOGN'(base);
    s.lvls = LOGE'(lvls);
    s.idx  = LOGN'(idx);
    s.p    = pv;
    s.diff = LOGE'(d);
    sq.push_back(s);
  endtask

  task automatic push_done(input logic e, input int lat);
    done_t d;
    d.err = e;
    d.lat = 32'(lat);
    dq.push_back(d);
  endtask

  task automatic send(input logic [LOGE-1:0] d, input logic [FSIZE-1:0] pv);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_p = pv;
    cmd_diff_logN = d;
    acc_cyc = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (dones_seen < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", dones_seen >= target, 1);
  endtask

  task automatic run_b(input logic [LOGE_B-1:0] d, input int exp_starts, input int exp_base,
                       input int exp_lvls, input int exp_lat);
    int n_st = 0;
    int lat = -1;
    int n = 0;
    int a;
    @(negedge clk);
    chk("b_cmd_ready", cmd_ready_b, 1);
    cmd_valid_b = 1'b1;
    cmd_p_b = 32'h00B0_0000 | 32'(d);
    cmd_diff_logN_b = d;
    a = cyc + 1;
    @(negedge clk);
    cmd_valid_b = 1'b0;
    while (lat < 0 && n < 200) begin
      if (start_NTT_b) begin
        n_st++;
        chk("b_base_level", NTT_base_level_b, exp_base);
        chk("b_levels", NTT_levels_b, exp_lvls);
      end
      if (done_b) lat = cyc - a + 2;
      if (lat < 0) begin
        @(negedge clk);
        n++;
      end
    end
    chk("b_start_count", n_st, exp_starts);
    chk("b_latency", lat, exp_lat);
  endtask

  initial begin
    vec_t tbl[5];
    int done_target = 0;
    int t0;
    int n;

    tbl[0] = '{diff: 3'd0, p: 32'hA000_0001, w: 8'd10, k: 4'd5,
               base: {13'd0, 13'd1, 13'd4, 13'd7, 13'd10}, lvls: {3'd1, 3'd3, 3'd3, 3'd3, 3'd3}};
    tbl[1] = '{diff: 3'd1, p: 32'hA000_0002, w: 8'd10, k: 4'd4,
               base: {13'd0, 13'd0, 13'd3, 13'd6, 13'd9}, lvls: {3'd0, 3'd3, 3'd3, 3'd3, 3'd3}};
    tbl[2] = '{diff: 3'd5, p: 32'hA000_0003, w: 8'd3, k: 4'd3,
               base: {13'd0, 13'd0, 13'd0, 13'd2, 13'd5}, lvls: {3'd0, 3'd0, 3'd2, 3'd3, 3'd3}};
    tbl[3] = '{diff: 3'd7, p: 32'hA000_0004, w: 8'd1, k: 4'd2,
               base: {13'd0, 13'd0, 13'd0, 13'd0, 13'd3}, lvls: {3'd0, 3'd0, 3'd0, 3'd3, 3'd3}};
    tbl[4] = '{diff: 3'd6, p: 32'hA000_0005, w: 8'd2, k: 4'd3,
               base: {13'd0, 13'd0, 13'd0, 13'd1, 13'd4}, lvls: {3'd0, 3'd0, 3'd1, 3'd3, 3'd3}};

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_start", start_NTT, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_pass_idx", pass_idx, 0);
    chk("rst_levels", NTT_levels, 0);
    chk("rst_base", NTT_base_level, 0);
    chk("rst_p", p, 0);
    chk("rst_b_cmd_ready", cmd_ready_b, 1);
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      w_a = int'(tbl[i].w);
      for (int j = 0; j < int'(tbl[i].k); j++)
        push_start(int'(tbl[i].base[j]), int'(tbl[i].lvls[j]), j, tbl[i].p, int'(tbl[i].diff));
      push_done(1'b0, 2 + int'(tbl[i].k) * (2 + int'(tbl[i].w)));
      send(tbl[i].diff, tbl[i].p);
      done_target++;
      wait_done(done_target);
    end

    // Command held during WAIT_DONE is ignored.
    w_a = 10;
    push_start(3, 3, 0, 32'h0000_1234, 7);
    push_start(0, 3, 1, 32'h0000_1234, 7);
    push_done(1'b0, 2 + 2 * 12);
    send(3'd7, 32'h0000_1234);
    repeat (4) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_p = 32'h0000_BEEF;
    cmd_diff_logN = 3'd0;
    chk("busy_cmd_ready", cmd_ready, 0);
    done_target++;
    wait_done(done_target);
    cmd_valid = 1'b0;
    chk("p_held", p, 32'h0000_1234);
    repeat (5) @(negedge clk);
    chk("single_done", dones_seen, done_target);

    // Working never drops: timeout in WAIT_DONE.
    hang_a = 1'b1;
    w_a = 3;
    push_start(3, 3, 0, 32'h0000_5555, 7);
    push_done(1'b1, 20);
    send(3'd7, 32'h0000_5555);
    done_target++;
    wait_done(done_target);
    repeat (3) @(negedge clk);
    chk("error_sticky", error, 1);
    hang_a = 1'b0;
    repeat (10) @(negedge clk);
    push_start(3, 3, 0, 32'h0000_7777, 7);
    push_start(0, 3, 1, 32'h0000_7777, 7);
    push_done(1'b0, 2 + 2 * 5);
    send(3'd7, 32'h0000_7777);
    chk("error_cleared", error, 0);
    done_target++;
    wait_done(done_target);

    // Reset during pass 2 WAIT_DONE.
    w_a = 10;
    push_start(10, 3, 0, 32'h0000_6666, 0);
    push_start(7, 3, 1, 32'h0000_6666, 0);
    push_start(4, 3, 2, 32'h0000_6666, 0);
    t0 = starts_seen;
    send(3'd0, 32'h0000_6666);
    n = 0;
    while (starts_seen < t0 + 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pass2", starts_seen >= t0 + 3, 1);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_start", start_NTT, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_p", p, 0);
    chk("mid_rst_levels", NTT_levels, 0);
    chk("mid_rst_base", NTT_base_level, 0);
    chk("mid_rst_diff", diff_logN, 0);
    chk("mid_rst_pass_idx", pass_idx, 0);
    chk("mid_rst_error", error, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    w_a = 3;
    push_start(9, 3, 0, 32'h0000_8888, 1);
    push_start(6, 3, 1, 32'h0000_8888, 1);
    push_start(3, 3, 2, 32'h0000_8888, 1);
    push_start(0, 3, 3, 32'h0000_8888, 1);
    push_done(1'b0, 2 + 4 * 5);
    send(3'd1, 32'h0000_8888);
    done_target++;
    wait_done(done_target);

    // Wider-lane instance: single partial pass, empty ring, saturated diff.
    run_b(4'd11, 1, 0, 2, 8);
    run_b(4'd13, 0, 0, 0, 2);
    run_b(4'd15, 0, 0, 0, 2);

    repeat (3) @(negedge clk);
    chk("starts_left", sq.size(), 0);
    chk("dones_left", dq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
